// File: rtl/latency_memory_responder.sv
// Data-memory responder with valid/ready request/response handshakes and a fixed access latency.
// Define LATENCY_RESPONDER_BACKTOBACK_EN to let a new accept share an edge with a response handshake.
module latency_memory_responder #(
    parameter int unsigned BIT_COUNT    = 32,
    parameter int unsigned MEMORY_WORDS = 100,
    parameter int unsigned LATENCY      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ReqValid,
    output logic                 ReqReady,
    input  logic                 ReqWrite,
    input  logic [3:0]           ReqByteEn,
    input  logic [BIT_COUNT-1:0] ReqAdr,
    input  logic [31:0]          ReqWriteData,
    output logic                 RespValid,
    input  logic                 RespReady,
    output logic [31:0]          RespReadData,
    output logic                 RespError
);
    localparam int unsigned IdxW  = (MEMORY_WORDS > 1) ? $clog2(MEMORY_WORDS) : 1;
    localparam int unsigned WordW = BIT_COUNT - 2;

    typedef enum logic [1:0] {StIdle, StWait, StResp} stateT;

    stateT            stateQ, stateD;
    logic [3:0]       counterQ, counterD;
    logic             writeQ;
    logic [3:0]       byteEnQ;
    logic [WordW-1:0] wordQ;
    logic [31:0]      dataQ;

    logic [31:0] mem [MEMORY_WORDS] = '{default: 32'h0};

    logic             accept, respFire, enterResp;
    logic             curWrite;
    logic [3:0]       curByteEn;
    logic [WordW-1:0] curWord;
    logic [31:0]      curData;
    logic             inRange;
    logic [IdxW-1:0]  memIdx;
    logic             unusedAdrBits;

    assign unusedAdrBits = ^ReqAdr[1:0];
    assign RespValid     = (stateQ == StResp);

    // With a single-cycle latency the access happens at the accept edge, so use the live request.
    always_comb begin
        if (LATENCY == 1) begin
            curWrite  = ReqWrite;
            curByteEn = ReqByteEn;
            curWord   = ReqAdr[BIT_COUNT-1:2];
            curData   = ReqWriteData;
        end else begin
            curWrite  = writeQ;
            curByteEn = byteEnQ;
            curWord   = wordQ;
            curData   = dataQ;
        end
        inRange = (curWord < WordW'(MEMORY_WORDS));
        memIdx  = curWord[IdxW-1:0];
    end

    always_comb begin
        stateD    = stateQ;
        counterD  = counterQ;
        enterResp = 1'b0;
        ReqReady  = (stateQ == StIdle);
`ifdef LATENCY_RESPONDER_BACKTOBACK_EN
        ReqReady  = ReqReady || ((stateQ == StResp) && RespReady);
`endif
        accept    = ReqValid && ReqReady;
        respFire  = (stateQ == StResp) && RespReady;

        unique case (stateQ)
            StIdle: ;
            StWait: begin
                if (counterQ == 4'd0) begin
                    stateD    = StResp;
                    enterResp = 1'b1;
                end else begin
                    counterD = counterQ - 4'd1;
                end
            end
            StResp: begin
                if (respFire) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase

        if (accept) begin
            if (LATENCY == 1) begin
                stateD    = StResp;
                enterResp = 1'b1;
            end else begin
                stateD   = StWait;
                counterD = 4'(LATENCY - 2);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stateQ       <= StIdle;
            counterQ     <= 4'd0;
            writeQ       <= 1'b0;
            byteEnQ      <= 4'd0;
            wordQ        <= '0;
            dataQ        <= 32'd0;
            RespReadData <= 32'd0;
            RespError    <= 1'b0;
        end else begin
            stateQ   <= stateD;
            counterQ <= counterD;
            if (accept) begin
                writeQ  <= ReqWrite;
                byteEnQ <= ReqByteEn;
                wordQ   <= ReqAdr[BIT_COUNT-1:2];
                dataQ   <= ReqWriteData;
            end
            if (enterResp) begin
                RespError    <= !inRange;
                RespReadData <= (!curWrite && inRange) ? mem[memIdx] : 32'd0;
            end else if (respFire) begin
                RespError    <= 1'b0;
                RespReadData <= 32'd0;
            end
        end
    end

    // Storage is deliberately outside the reset domain; reset only blocks a pending commit.
    always_ff @(posedge clk) begin
        if (reset && enterResp && curWrite && inRange) begin
            for (int i = 0; i < 4; i++) begin
                if (curByteEn[i]) begin
                    mem[memIdx][8*i +: 8] <= curData[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_latency_memory_responder.sv
// Bench for latency_memory_responder: two instances (latency 2 and 1) checked every cycle
// against a transaction-level model, plus directed scenarios with literal expectations.
module tb_latency_memory_responder;
    localparam int MEMW = 100;
`ifdef LATENCY_RESPONDER_BACKTOBACK_EN
    localparam bit BB = 1'b1;
`else
    localparam bit BB = 1'b0;
`endif

    logic        clk;
    logic        rstN;
    logic        reqValid  [2];
    logic        reqWrite  [2];
    logic [3:0]  reqByteEn [2];
    logic [31:0] reqAdr    [2];
    logic [31:0] reqWd     [2];
    logic        respReady [2];
    logic        reqReadyO [2];
    logic        respValidO[2];
    logic [31:0] respDataO [2];
    logic        respErrO  [2];

    int checks = 0;
    int errors = 0;

    // Behavioural model state, one set per instance
    int          latCfg [2] = '{2, 1};
    bit          mWait  [2];
    int          mRem   [2];
    bit          mValid [2];
    bit [31:0]   mData  [2];
    bit          mErr   [2];
    bit          mWr    [2];
    bit [3:0]    mBe    [2];
    bit [31:0]   mAdr   [2];
    bit [31:0]   mWd    [2];
    bit [31:0]   mMem   [2][MEMW];

    latency_memory_responder #(.BIT_COUNT(32), .MEMORY_WORDS(MEMW), .LATENCY(2)) dut0 (
        .clk(clk), .reset(rstN),
        .ReqValid(reqValid[0]), .ReqReady(reqReadyO[0]), .ReqWrite(reqWrite[0]),
        .ReqByteEn(reqByteEn[0]), .ReqAdr(reqAdr[0]), .ReqWriteData(reqWd[0]),
        .RespValid(respValidO[0]), .RespReady(respReady[0]),
        .RespReadData(respDataO[0]), .RespError(respErrO[0])
    );

    latency_memory_responder #(.BIT_COUNT(32), .MEMORY_WORDS(MEMW), .LATENCY(1)) dut1 (
        .clk(clk), .reset(rstN),
        .ReqValid(reqValid[1]), .ReqReady(reqReadyO[1]), .ReqWrite(reqWrite[1]),
        .ReqByteEn(reqByteEn[1]), .ReqAdr(reqAdr[1]), .ReqWriteData(reqWd[1]),
        .RespValid(respValidO[1]), .RespReady(respReady[1]),
        .RespReadData(respDataO[1]), .RespError(respErrO[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit modelReady(input int d);
        return (!mWait[d] && !mValid[d]) || (BB && mValid[d] && respReady[d]);
    endfunction

    task automatic produce(input int d);
        int idx;
        idx = int'(mAdr[d] >> 2);
        mValid[d] = 1'b1;
        if (idx >= MEMW) begin
            mErr[d]  = 1'b1;
            mData[d] = 32'd0;
        end else begin
            mErr[d] = 1'b0;
            if (mWr[d]) begin
                for (int b = 0; b < 4; b++)
                    if (mBe[d][b]) mMem[d][idx][8*b +: 8] = mWd[d][8*b +: 8];
                mData[d] = 32'd0;
            end else begin
                mData[d] = mMem[d][idx];
            end
        end
    endtask

    task automatic modelStep(input int d);
        bit acc, fire;
        if (!rstN) begin
            mWait[d]  = 1'b0;
            mValid[d] = 1'b0;
            mData[d]  = 32'd0;
            mErr[d]   = 1'b0;
        end else begin
            acc  = reqValid[d] && modelReady(d);
            fire = mValid[d] && respReady[d];
            if (fire) begin
                mValid[d] = 1'b0;
                mData[d]  = 32'd0;
                mErr[d]   = 1'b0;
            end
            if (mWait[d]) begin
                mRem[d]--;
                if (mRem[d] == 0) begin
                    mWait[d] = 1'b0;
                    produce(d);
                end
            end
            if (acc) begin
                mWr[d]  = reqWrite[d];
                mBe[d]  = reqByteEn[d];
                mAdr[d] = reqAdr[d];
                mWd[d]  = reqWd[d];
                if (latCfg[d] == 1) begin
                    produce(d);
                end else begin
                    mWait[d] = 1'b1;
                    mRem[d]  = latCfg[d] - 1;
                end
            end
        end
    endtask

    // Model advances on the edge; outputs compared just after it settles.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) modelStep(d);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d ReqReady", d), 32'(reqReadyO[d]), 32'(modelReady(d)));
            check($sformatf("d%0d RespValid", d), 32'(respValidO[d]), 32'(mValid[d]));
            check($sformatf("d%0d RespReadData", d), respDataO[d], mData[d]);
            check($sformatf("d%0d RespError", d), 32'(respErrO[d]), 32'(mErr[d]));
        end
    end

    task automatic txn(input int d, input bit wr, input bit [3:0] be, input bit [31:0] adr,
                       input bit [31:0] wd, input int stall, input bit [31:0] expStall,
                       output bit [31:0] rd, output bit er, output int lt);
        int n;
        @(negedge clk);
        reqValid[d]  = 1'b1;
        reqWrite[d]  = wr;
        reqByteEn[d] = be;
        reqAdr[d]    = adr;
        reqWd[d]     = wd;
        respReady[d] = 1'b0;
        #1;
        n = 0;
        while (!reqReadyO[d] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check($sformatf("d%0d accept wait", d), 32'(reqReadyO[d]), 32'd1);
        @(negedge clk);
        reqValid[d]  = 1'b0;
        reqWrite[d]  = 1'($urandom_range(0, 1));
        reqByteEn[d] = 4'($urandom);
        reqAdr[d]    = $urandom;
        reqWd[d]     = $urandom;
        lt = 1;
        while (!respValidO[d] && lt < 20) begin
            @(negedge clk);
            lt++;
        end
        check($sformatf("d%0d response wait", d), 32'(respValidO[d]), 32'd1);
        rd = respDataO[d];
        er = respErrO[d];
        for (int i = 0; i < stall; i++) begin
            check($sformatf("d%0d stall valid", d), 32'(respValidO[d]), 32'd1);
            check($sformatf("d%0d stall data", d), respDataO[d], expStall);
            check($sformatf("d%0d stall ReqReady", d), 32'(reqReadyO[d]), 32'd0);
            @(negedge clk);
        end
        respReady[d] = 1'b1;
        @(negedge clk);
        respReady[d] = 1'b0;
        if (stall > 0)
            check($sformatf("d%0d ReqReady after handshake", d), 32'(reqReadyO[d]), 32'd1);
    endtask

    function automatic bit [31:0] pickAdr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8) return 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
        if (r == 8) return 32'(($urandom_range(96, 103) << 2) | $urandom_range(0, 3));
        return $urandom;
    endfunction

    initial begin
        bit [31:0] rd;
        bit        er;
        int        lt;
        int        k, got, first, last;
        bit        accNext;

        rstN = 1'b0;
        for (int d = 0; d < 2; d++) begin
            reqValid[d]  = 1'b0;
            reqWrite[d]  = 1'b0;
            reqByteEn[d] = 4'd0;
            reqAdr[d]    = 32'd0;
            reqWd[d]     = 32'd0;
            respReady[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        check("reset ReqReady", 32'(reqReadyO[0]), 32'd1);
        check("reset RespValid", 32'(respValidO[0]), 32'd0);
        check("reset RespReadData", respDataO[0], 32'd0);
        check("reset RespError", 32'(respErrO[0]), 32'd0);

        // Write then read back with latency 2
        txn(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 32'd0, rd, er, lt);
        check("write latency", lt, 32'd2);
        check("write data", rd, 32'd0);
        check("write err", 32'(er), 32'd0);
        txn(0, 1'b0, 4'hF, 32'h10, 32'd0, 0, 32'd0, rd, er, lt);
        check("read latency", lt, 32'd2);
        check("read data", rd, 32'hDEADBEEF);
        check("read err", 32'(er), 32'd0);

        // Partial byte lanes, then a no-lane write, then a stalled read
        txn(0, 1'b1, 4'hF, 32'h14, 32'h11223344, 0, 32'd0, rd, er, lt);
        txn(0, 1'b1, 4'b0101, 32'h14, 32'hAABBCCDD, 0, 32'd0, rd, er, lt);
        txn(0, 1'b1, 4'b0000, 32'h17, 32'hFFFFFFFF, 0, 32'd0, rd, er, lt);
        txn(0, 1'b0, 4'h0, 32'h14, 32'd0, 5, 32'h11BB33DD, rd, er, lt);
        check("byte-lane read", rd, 32'h11BB33DD);

        // Out-of-range accesses
        txn(0, 1'b0, 4'hF, 32'h190, 32'd0, 0, 32'd0, rd, er, lt);
        check("oor read err", 32'(er), 32'd1);
        check("oor read data", rd, 32'd0);
        txn(0, 1'b1, 4'hF, 32'h190, 32'hCAFEF00D, 0, 32'd0, rd, er, lt);
        check("oor write err", 32'(er), 32'd1);
        for (int i = 0; i < MEMW; i++) txn(0, 1'b0, 4'hF, 32'(4 * i), 32'd0, 0, 32'd0, rd, er, lt);

        // Reset during WAIT discards the pending write
        txn(0, 1'b1, 4'hF, 32'h20, 32'h0BADF00D, 0, 32'd0, rd, er, lt);
        @(negedge clk);
        reqValid[0] = 1'b1; reqWrite[0] = 1'b1; reqByteEn[0] = 4'hF;
        reqAdr[0] = 32'h20; reqWd[0] = 32'hFFFFFFFF; respReady[0] = 1'b0;
        #1 check("pre-reset ReqReady", 32'(reqReadyO[0]), 32'd1);
        @(negedge clk);
        reqValid[0] = 1'b0;
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        check("mid-reset ReqReady", 32'(reqReadyO[0]), 32'd1);
        check("mid-reset RespValid", 32'(respValidO[0]), 32'd0);
        check("mid-reset RespReadData", respDataO[0], 32'd0);
        check("mid-reset RespError", 32'(respErrO[0]), 32'd0);
        txn(0, 1'b0, 4'hF, 32'h20, 32'd0, 0, 32'd0, rd, er, lt);
        check("after-reset read", rd, 32'h0BADF00D);

        // Latency-1 streaming of four reads
        for (int i = 0; i < 4; i++) begin
            txn(1, 1'b1, 4'hF, 32'(4 * i), 32'hA0000000 + 32'(i), 0, 32'd0, rd, er, lt);
            check("lat1 write latency", lt, 32'd1);
        end
        @(negedge clk);
        k = 0; got = 0; first = -1; last = -1;
        reqValid[1] = 1'b1; reqWrite[1] = 1'b0; reqByteEn[1] = 4'hF;
        reqAdr[1] = 32'd0; respReady[1] = 1'b1;
        #1 accNext = reqReadyO[1];
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge clk);
            if (respValidO[1]) begin
                check("stream data", respDataO[1], 32'hA0000000 + 32'(got));
                if (first < 0) first = c;
                last = c;
                got++;
            end
            if (accNext) begin
                k++;
                if (k == 4) reqValid[1] = 1'b0;
                else reqAdr[1] = 32'(4 * k);
            end
            #1 accNext = reqValid[1] && reqReadyO[1];
        end
        reqValid[1] = 1'b0;
        respReady[1] = 1'b0;
        check("stream count", got, 32'd4);
        check("stream span", last - first, BB ? 32'd3 : 32'd6);

        // Randomized traffic on both instances, occasional reset
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rstN = ($urandom_range(0, 79) != 0);
            for (int d = 0; d < 2; d++) begin
                reqValid[d]  = 1'($urandom_range(0, 1));
                reqWrite[d]  = 1'($urandom_range(0, 1));
                reqByteEn[d] = 4'($urandom);
                reqAdr[d]    = pickAdr();
                reqWd[d]     = $urandom;
                respReady[d] = ($urandom_range(0, 9) < 6);
            end
        end
        @(negedge clk);
        rstN = 1'b1;
        for (int d = 0; d < 2; d++) begin
            reqValid[d]  = 1'b0;
            respReady[d] = 1'b1;
        end
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
